sync_fifo_ctl: RTL and testbench

//  Parametrised synchronous FIFO, the successor to the basic fifo. Adds:
//   - any depth >= 2, not restricted to 2^n
//   - selectable first-word-fall-through (FWFT) or registered-read mode
//   - programmable almost-full / almost-empty flags
//   - sticky overflow / underflow error flags

---
 rtl/sync_fifo_ctl.sv | 93 +++++++++
 tb/tb_sync_fifo_ctl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctl.sv
// sync_fifo_ctl: parametrised synchronous FIFO with FWFT or registered read, threshold flags and sticky errors
module sync_fifo_ctl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 6,
  parameter bit FWFT       = 1,
  parameter int AF_THRES   = DEPTH - 1,
  parameter int AE_THRES   = 1,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  err_clr_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  full_o,
  output logic                  afull_o,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  rvalid_o,
  output logic                  empty_o,
  output logic                  aempty_o,
  output logic [CNT_W-1:0]      cnt_o,
  output logic                  ovf_o,
  output logic                  udf_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  if (DEPTH < 2 || AF_THRES < 1 || AF_THRES > DEPTH || AE_THRES < 0 || AE_THRES > DEPTH - 1) begin : g_param_err
    $error("sync_fifo_ctl: illegal DEPTH or threshold parameters");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      cnt;
  logic                  ovf, udf, push_hs, pop_hs;

  assign full_o   = cnt == CNT_W'(DEPTH);
  assign empty_o  = cnt == '0;
  assign afull_o  = cnt >= CNT_W'(AF_THRES);
  assign aempty_o = cnt <= CNT_W'(AE_THRES);
  assign cnt_o    = cnt;
  assign ovf_o    = ovf;
  assign udf_o    = udf;
  assign push_hs  = push_i & ~full_o & ~flush_i;
  assign pop_hs   = pop_i & ~empty_o & ~flush_i;

  // storage write; contents are deliberately left unreset
  always_ff @(posedge clk_i)
    if (push_hs) mem[wr_ptr] <= dat_i;

  // occupancy, wrapping pointers and sticky error flags; flush wins over push/pop but keeps errors
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      ovf <= (ovf & ~err_clr_i) | (push_i & full_o & ~flush_i);
      udf <= (udf & ~err_clr_i) | (pop_i & empty_o & ~flush_i);
      if (flush_i) begin
        cnt    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        cnt <= cnt + CNT_W'(push_hs) - CNT_W'(pop_hs);
        if (push_hs) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
        if (pop_hs) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      end
    end

  if (FWFT) begin : g_fwft
    assign dat_o    = empty_o ? '0 : mem[rd_ptr];
    assign rvalid_o = ~empty_o;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] dat_q;
    logic                  rvalid_q;
    // registered read: load head on a pop handshake, pulse valid for one cycle
    always_ff @(posedge clk_i)
      if (!rst_n_i) begin
        dat_q    <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= pop_hs;
        if (pop_hs) dat_q <= mem[rd_ptr];
      end
    assign dat_o    = dat_q;
    assign rvalid_o = rvalid_q;
  end
endmodule

// File: tb/tb_sync_fifo_ctl.sv
// tb_sync_fifo_ctl: self-checking bench for sync_fifo_ctl in FWFT and registered-read modes against a queue model
module tb_sync_fifo_ctl;
  localparam int DW = 32;
  localparam int DEPTH = 6;

  logic clk = 0, rst_n = 0, flush = 0, err_clr = 0, push = 0, pop = 0;
  logic [DW-1:0] din = '0;
  logic full, afull, rv1, empty, aempty, ovf, udf;
  logic full0, afull0, rv0, empty0, aempty0, ovf0, udf0;
  logic [DW-1:0] dat1, dat0;
  logic [2:0] cnt, cnt0;

  logic [DW-1:0] q[$];
  bit m_ovf, m_udf, m_rv0;
  logic [DW-1:0] m_d0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sync_fifo_ctl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_f1 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .err_clr_i(err_clr), .push_i(push), .dat_i(din),
    .full_o(full), .afull_o(afull), .pop_i(pop), .dat_o(dat1), .rvalid_o(rv1), .empty_o(empty),
    .aempty_o(aempty), .cnt_o(cnt), .ovf_o(ovf), .udf_o(udf));

  sync_fifo_ctl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_f0 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .err_clr_i(err_clr), .push_i(push), .dat_i(din),
    .full_o(full0), .afull_o(afull0), .pop_i(pop), .dat_o(dat0), .rvalid_o(rv0), .empty_o(empty0),
    .aempty_o(aempty0), .cnt_o(cnt0), .ovf_o(ovf0), .udf_o(udf0));

  // drive one cycle of inputs, advance the queue model across the edge, leave outputs settled
  task automatic step(input bit r, input bit p, input logic [DW-1:0] d, input bit o, input bit f, input bit c);
    bit was_full, was_empty;
    rst_n = ~r; push = p; din = d; pop = o; flush = f; err_clr = c;
    was_full = q.size() == DEPTH;
    was_empty = q.size() == 0;
    @(posedge clk);
    if (r) begin
      q.delete(); m_ovf = 0; m_udf = 0; m_rv0 = 0; m_d0 = '0;
    end else begin
      m_ovf = (m_ovf && !c) || (p && was_full && !f);
      m_udf = (m_udf && !c) || (o && was_empty && !f);
      m_rv0 = 0;
      if (f) q.delete();
      else begin
        if (o && !was_empty) begin m_d0 = q.pop_front(); m_rv0 = 1; end
        if (p && !was_full) q.push_back(d);
      end
    end
    #1;
    rst_n = 1; push = 0; pop = 0; flush = 0; err_clr = 0;
  endtask

  task automatic test_reset();
    step(1, 1, 32'hDEAD, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    checks++; if ({full, afull, empty, aempty} !== 4'b0011) begin errors++; $display("FAIL reset_flags got %b want 0011", {full, afull, empty, aempty}); end
    checks++; if (dat1 !== '0 || dat0 !== '0) begin errors++; $display("FAIL reset_dat got %h/%h want 0/0", dat1, dat0); end
    checks++; if ({rv1, rv0, ovf, udf, ovf0, udf0} !== 6'b0) begin errors++; $display("FAIL reset_misc got %b want 000000", {rv1, rv0, ovf, udf, ovf0, udf0}); end
  endtask

  task automatic test_fill_ovf();
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 32'hA0 + i, 0, 0, 0);
      checks++; if (cnt !== 3'(i + 1)) begin errors++; $display("FAIL fill_cnt got %0d want %0d", cnt, i + 1); end
      checks++; if ({full, afull} !== {i == DEPTH - 1, i >= DEPTH - 2}) begin errors++; $display("FAIL fill_flags at %0d got %b", i + 1, {full, afull}); end
      checks++; if (dat1 !== 32'hA0) begin errors++; $display("FAIL fill_head got %h want a0", dat1); end
    end
    step(0, 1, 32'hA6, 0, 0, 0);
    checks++; if ({ovf, ovf0, cnt} !== {2'b11, 3'd6}) begin errors++; $display("FAIL ovf_set got %b %b cnt %0d want 1 1 cnt 6", ovf, ovf0, cnt); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (dat1 !== 32'hA0 + i) begin errors++; $display("FAIL fwft_head got %h want %h", dat1, 32'hA0 + i); end
      step(0, 0, 0, 1, 0, 0);
      checks++; if (dat0 !== 32'hA0 + i || rv0 !== 1'b1) begin errors++; $display("FAIL reg_pop got %h rv %b want %h rv 1", dat0, rv0, 32'hA0 + i); end
    end
    checks++; if ({empty, cnt, udf} !== {1'b1, 3'd0, 1'b0}) begin errors++; $display("FAIL drained got empty %b cnt %0d udf %b", empty, cnt, udf); end
    step(0, 0, 0, 0, 0, 1);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", ovf); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) step(0, 1, 32'hB00 + i, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 32'hB03 + i, 1, 0, 0);
      checks++; if (cnt !== 3'd3 || dat0 !== 32'hB00 + i || rv0 !== 1'b1) begin errors++; $display("FAIL wrap cnt %0d dat %h want 3 %h", cnt, dat0, 32'hB00 + i); end
      checks++; if (dat1 !== 32'hB01 + i) begin errors++; $display("FAIL wrap_head got %h want %h", dat1, 32'hB01 + i); end
    end
    checks++; if ({ovf, udf, full, empty} !== 4'b0) begin errors++; $display("FAIL wrap_flags got %b want 0000", {ovf, udf, full, empty}); end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
    checks++; if (dat0 !== 32'hB16 || !empty) begin errors++; $display("FAIL wrap_drain got %h empty %b want b16 1", dat0, empty); end
  endtask

  task automatic test_underflow();
    step(0, 0, 0, 1, 0, 0);
    checks++; if ({udf, udf0, cnt, rv0} !== {2'b11, 3'd0, 1'b0}) begin errors++; $display("FAIL udf_set got %b%b cnt %0d rv %b", udf, udf0, cnt, rv0); end
    step(0, 0, 0, 1, 0, 1);
    checks++; if (udf !== 1'b1) begin errors++; $display("FAIL udf_clr_collide got %b want 1", udf); end
    step(0, 0, 0, 0, 0, 1);
    checks++; if (udf !== 1'b0) begin errors++; $display("FAIL udf_clr got %b want 0", udf); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < DEPTH; i++) step(0, 1, 32'hC0 + i, 0, 0, 0);
    step(0, 1, 32'hCF, 1, 0, 0);
    checks++; if ({cnt, ovf} !== {3'd5, 1'b1} || dat0 !== 32'hC0) begin errors++; $display("FAIL full_push_pop cnt %0d ovf %b dat %h want 5 1 c0", cnt, ovf, dat0); end
    step(0, 0, 0, 1, 0, 0);
    checks++; if (cnt !== 3'd4) begin errors++; $display("FAIL pre_flush got %0d want 4", cnt); end
    step(0, 1, 32'hEE, 0, 1, 0);
    checks++; if ({cnt, empty, ovf, rv0, udf} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL flush cnt %0d empty %b ovf %b rv %b udf %b", cnt, empty, ovf, rv0, udf); end
    step(0, 1, 32'h55, 0, 0, 0);
    checks++; if (dat1 !== 32'h55) begin errors++; $display("FAIL flush_head got %h want 55", dat1); end
    step(0, 0, 0, 1, 0, 1);
    checks++; if (dat0 !== 32'h55 || ovf !== 1'b0) begin errors++; $display("FAIL flush_read got %h ovf %b want 55 0", dat0, ovf); end
  endtask

  task automatic test_fwft0();
    step(0, 1, 32'h11, 0, 0, 0);
    checks++; if (rv0 !== 1'b0 || dat1 !== 32'h11 || rv1 !== 1'b1) begin errors++; $display("FAIL f0_push rv0 %b dat1 %h rv1 %b", rv0, dat1, rv1); end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    checks++; if (dat0 !== 32'h11 || rv0 !== 1'b1) begin errors++; $display("FAIL f0_pop got %h rv %b want 11 1", dat0, rv0); end
    step(0, 0, 0, 0, 0, 0);
    checks++; if (dat0 !== 32'h11 || rv0 !== 1'b0 || dat1 !== '0) begin errors++; $display("FAIL f0_hold got %h rv %b dat1 %h", dat0, rv0, dat1); end
  endtask

  task automatic test_random();
    int sz;
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 50) % 2 ? 30 : 70;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < bias, $urandom, $urandom_range(0, 99) < 100 - bias,
           $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0);
      sz = q.size();
      checks++; if (cnt !== 3'(sz) || cnt0 !== 3'(sz)) begin errors++; $display("FAIL rnd_cnt %0d/%0d want %0d", cnt, cnt0, sz); end
      checks++; if ({full, afull, empty, aempty} !== {sz == DEPTH, sz >= DEPTH - 1, sz == 0, sz <= 1} ||
                    {full0, afull0, empty0, aempty0} !== {full, afull, empty, aempty}) begin
        errors++; $display("FAIL rnd_flags got %b want %b", {full, afull, empty, aempty}, {sz == DEPTH, sz >= DEPTH - 1, sz == 0, sz <= 1});
      end
      checks++; if (dat1 !== (sz ? q[0] : '0) || rv1 !== (sz != 0)) begin errors++; $display("FAIL rnd_fwft got %h rv %b", dat1, rv1); end
      checks++; if (dat0 !== m_d0 || rv0 !== m_rv0) begin errors++; $display("FAIL rnd_reg got %h rv %b want %h rv %b", dat0, rv0, m_d0, m_rv0); end
      checks++; if ({ovf, udf, ovf0, udf0} !== {m_ovf, m_udf, m_ovf, m_udf}) begin errors++; $display("FAIL rnd_err got %b want %b%b", {ovf, udf, ovf0, udf0}, m_ovf, m_udf); end
    end
  endtask

  initial begin
    test_reset();
    test_fill_ovf();
    test_wrap();
    test_underflow();
    test_flush();
    test_fwft0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
